dbg_dump_sequencer: RTL and testbench

Sequences the post-halt / post-step state dump of the MIPS core to the debug UART.
- Word order: PC, cycle count, every register-file entry, then the first DATA_MEM_WORDS data-memory words.
- Drives the register-select and data-memory address buses itself.
- Serializes each 32-bit word MSB-first onto a byte-wide valid/ready TX interface in front of the UART transmitter.
- Started by the debug FSM with a single pulse; reports busy/done back to it.

---
 rtl/dbg_pkg.sv | 38 +++
 rtl/dbg_dump_sequencer_if.sv | 11 +
 rtl/dbg_word_serializer.sv | 40 ++++
 rtl/dbg_dump_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dbg_dump_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared types and sizing helpers for the debug state-dump sequencer.
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } dbg_state_e;

  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_CYC = 2'd1,
    SEC_REG = 2'd2,
    SEC_MEM = 2'd3
  } dbg_sec_e;

  function automatic int bytes_per_word(input int nbits, input int data_bits);
    return nbits / data_bits;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(32, 8);

  function automatic int frame_bytes(input int nbits, input int data_bits,
                                     input int num_regs, input int mem_words);
    return (2 + num_regs + mem_words) * bytes_per_word(nbits, data_bits);
  endfunction

  // Index register must reach the larger of the two dumped arrays.
  function automatic int idx_width(input int num_regs, input int mem_words);
    int w;
    w = $clog2(num_regs);
    if ($clog2(mem_words) > w) w = $clog2(mem_words);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/dbg_dump_sequencer_if.sv
// Byte-wide valid/ready link between the dump sequencer and the UART transmitter.
interface dbg_dump_sequencer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_tx_data;
  logic                 o_tx_valid;
  logic                 i_tx_ready;

  modport master (output o_tx_data, output o_tx_valid, input i_tx_ready);
  modport slave  (input o_tx_data, input o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/dbg_word_serializer.sv
// Holds one dump word and shifts it out MSB byte first on each accepted transfer.
module dbg_word_serializer
  import dbg_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [NBITS-1:0]     word,
  input  logic                 valid,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 last_byte,
  output logic                 xfer
);
  localparam int BPW = bytes_per_word(NBITS, DATA_BITS);
  localparam int CW  = (BPW <= 2) ? 1 : $clog2(BPW);

  logic [NBITS-1:0] shift_q;
  logic [CW-1:0]    cnt_q;

  assign xfer      = valid && ready;
  assign tx_data   = shift_q[NBITS-1 -: DATA_BITS];
  assign last_byte = (cnt_q == CW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= word;
      cnt_q   <= '0;
    end else if (xfer) begin
      shift_q <= shift_q << DATA_BITS;
      cnt_q   <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/dbg_dump_sequencer.sv
// Walks PC, cycle count, register file and data memory, feeding each word to the
// byte serializer in front of the debug UART.
//   state | meaning
//   IDLE  | waiting for i_start
//   ADDR  | source address driven for the current word
//   WAIT  | read latency hold (skipped when READ_LATENCY = 0)
//   SEND  | bytes of the current word presented on the TX link
module dbg_dump_sequencer
  import dbg_pkg::*;
#(
  parameter int NBITS          = 32,
  parameter int DATA_BITS      = 8,
  parameter int NUM_REGS       = 32,
  parameter int DATA_MEM_WORDS = 16,
  parameter int READ_LATENCY   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  input  logic [NBITS-1:0]            i_pc,
  input  logic [NBITS-1:0]            i_cycle_count,
  output logic [$clog2(NUM_REGS)-1:0] o_reg_sel,
  input  logic [NBITS-1:0]            i_reg_data,
  output logic [NBITS-1:0]            o_mem_addr,
  input  logic [NBITS-1:0]            i_mem_data,
  dbg_dump_sequencer_if.master        tx
);
  localparam int RSW = $clog2(NUM_REGS);
  localparam int IW  = idx_width(NUM_REGS, DATA_MEM_WORDS);
  localparam int WW  = 2;

  dbg_state_e           state_q, state_d;
  dbg_sec_e             sec_q, sec_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic [NBITS-1:0]     snap_pc_q, snap_pc_d;
  logic [NBITS-1:0]     snap_cyc_q, snap_cyc_d;
  logic [RSW-1:0]       reg_sel_d;
  logic [NBITS-1:0]     mem_addr_d;
  logic                 done_q, done_d;
  logic                 load;
  logic                 last_byte;
  logic                 xfer;
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic [NBITS-1:0]     word_sel;

  assign tx_valid      = (state_q == SEND);
  assign tx.o_tx_valid = tx_valid;
  assign tx.o_tx_data  = tx_data;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;

  always_comb begin
    word_sel = snap_pc_q;
    case (sec_q)
      SEC_CYC: word_sel = snap_cyc_q;
      SEC_REG: word_sel = i_reg_data;
      SEC_MEM: word_sel = i_mem_data;
      default: ;
    endcase
  end

  dbg_word_serializer #(
    .NBITS     (NBITS),
    .DATA_BITS (DATA_BITS)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .word      (word_sel),
    .valid     (tx_valid),
    .ready     (tx.i_tx_ready),
    .tx_data   (tx_data),
    .last_byte (last_byte),
    .xfer      (xfer)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sec_q      <= SEC_PC;
      idx_q      <= '0;
      wcnt_q     <= '0;
      snap_pc_q  <= '0;
      snap_cyc_q <= '0;
      o_reg_sel  <= '0;
      o_mem_addr <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      snap_pc_q  <= snap_pc_d;
      snap_cyc_q <= snap_cyc_d;
      o_reg_sel  <= reg_sel_d;
      o_mem_addr <= mem_addr_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    snap_pc_d  = snap_pc_q;
    snap_cyc_d = snap_cyc_q;
    reg_sel_d  = o_reg_sel;
    mem_addr_d = o_mem_addr;
    done_d     = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          snap_pc_d  = i_pc;
          snap_cyc_d = i_cycle_count;
          sec_d      = SEC_PC;
          idx_d      = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (READ_LATENCY == 0) begin
          load    = 1'b1;
          state_d = SEND;
        end else begin
          wcnt_d  = WW'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          load    = 1'b1;
          state_d = SEND;
        end else begin
          wcnt_d = wcnt_q - WW'(1);
        end
      end
      SEND: begin
        if (xfer && last_byte) begin
          state_d = ADDR;
          case (sec_q)
            SEC_PC: sec_d = SEC_CYC;
            SEC_CYC: begin
              sec_d = SEC_REG;
              idx_d = '0;
            end
            SEC_REG: begin
              if (idx_q == IW'(NUM_REGS - 1)) begin
                sec_d = SEC_MEM;
                idx_d = '0;
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end
            default: begin
              if (idx_q == IW'(DATA_MEM_WORDS - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    // Addresses only move when a new word begins, so they stay put through SEND.
    if (state_d == ADDR && sec_d == SEC_REG) reg_sel_d  = idx_d[RSW-1:0];
    if (state_d == ADDR && sec_d == SEC_MEM) mem_addr_d = NBITS'({idx_d, 2'b00});
  end
endmodule

// File: tb/tb_dbg_dump_sequencer.sv
// Bench for dbg_dump_sequencer: three configurations, latency-modelled memories,
// byte capture compared with a frame built directly from the dumped contents.
module tb_dbg_dump_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready = 1'b1;
  bit   bp = 1'b0;
  int   ph = 0;
  int   cyc_cnt = 0;
  logic        start_v[3];
  logic [31:0] pc_v[3];
  logic [31:0] cyc_v[3];
  logic [31:0] regs[32];
  logic [31:0] mem[16];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_b[256];
  int   exp_n = 0;
  int   start_edge = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc_cnt++; end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp) begin ready = (ph == 0); ph = (ph + 1) % 3; end
      else ready = 1'b1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NR  = (g == 0) ? 32 : 4;
    localparam int DMW = (g == 0) ? 16 : 1;
    localparam int RL  = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
    localparam int RSW = $clog2(NR);

    logic busy_s, done_s, valid_s;
    logic [7:0] txd_s;
    logic [RSW-1:0] reg_sel_s;
    logic [31:0] mem_addr_s;
    logic [31:0] reg_data, mem_data;
    logic [31:0] rh[4];
    logic [31:0] mh[4];
    int cap_n = 0, done_n = 0, done_at = 0, viol = 0;
    logic [7:0] cap[2048];
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;

    dbg_dump_sequencer_if #(.DATA_BITS(8)) tx_if ();
    assign tx_if.i_tx_ready = ready;
    assign valid_s = tx_if.o_tx_valid;
    assign txd_s   = tx_if.o_tx_data;

    dbg_dump_sequencer #(
      .NBITS(32), .DATA_BITS(8), .NUM_REGS(NR), .DATA_MEM_WORDS(DMW), .READ_LATENCY(RL)
    ) u_dut (
      .clk(clk), .reset(reset), .i_start(start_v[g]), .o_busy(busy_s), .o_done(done_s),
      .i_pc(pc_v[g]), .i_cycle_count(cyc_v[g]), .o_reg_sel(reg_sel_s), .i_reg_data(reg_data),
      .o_mem_addr(mem_addr_s), .i_mem_data(mem_data), .tx(tx_if)
    );

    // Read data reflects the address seen RL clock edges earlier.
    initial begin
      for (int k = 0; k < 4; k++) begin rh[k] = 32'h0; mh[k] = 32'h0; end
      reg_data = 32'h0; mem_data = 32'h0;
      forever begin
        @(posedge clk); #1;
        for (int k = 3; k > 0; k--) begin rh[k] = rh[k-1]; mh[k] = mh[k-1]; end
        rh[0] = regs[reg_sel_s];
        mh[0] = mem[mem_addr_s[5:2]];
        reg_data = rh[RL];
        mem_data = mh[RL];
      end
    end

    always @(negedge clk) begin
      if (valid_s && ready && cap_n < 2048) begin cap[cap_n] = txd_s; cap_n++; end
      if (done_s) begin done_n++; done_at = cyc_cnt; end
      if (pv && !pr && !reset && (!valid_s || txd_s != pd)) viol++;
      pv = valid_s; pr = ready; pd = txd_s;
    end
  end

  function automatic int cap_n_of(input int g);
    case (g) 0: return g_dut[0].cap_n; 1: return g_dut[1].cap_n; default: return g_dut[2].cap_n; endcase
  endfunction
  function automatic logic [7:0] cap_of(input int g, input int i);
    case (g) 0: return g_dut[0].cap[i]; 1: return g_dut[1].cap[i]; default: return g_dut[2].cap[i]; endcase
  endfunction
  function automatic int done_n_of(input int g);
    case (g) 0: return g_dut[0].done_n; 1: return g_dut[1].done_n; default: return g_dut[2].done_n; endcase
  endfunction
  function automatic int done_at_of(input int g);
    case (g) 0: return g_dut[0].done_at; 1: return g_dut[1].done_at; default: return g_dut[2].done_at; endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected frame: words in dump order, each split into bytes MSB first.
  task automatic build_exp(input int nr, input int dmw, input logic [31:0] pcv, input logic [31:0] cycv);
    logic [31:0] v;
    exp_n = 0;
    for (int w = 0; w < 2 + nr + dmw; w++) begin
      if (w == 0) v = pcv;
      else if (w == 1) v = cycv;
      else if (w < 2 + nr) v = regs[w-2];
      else v = mem[w-2-nr];
      for (int b = 3; b >= 0; b--) begin
        exp_b[exp_n] = 8'((v >> (8 * b)) & 32'hFF);
        exp_n++;
      end
    end
  endtask

  task automatic check_frame(input int g, input int base, input string tag);
    int got, bad;
    got = cap_n_of(g) - base;
    bad = 0;
    chk({tag, "_len"}, got, exp_n);
    for (int i = 0; i < exp_n; i++)
      if (i < got && cap_of(g, base + i) !== exp_b[i]) bad++;
    chk({tag, "_bytes_bad"}, bad, 0);
  endtask

  task automatic start_pulse(input int g);
    @(posedge clk); #1; start_v[g] = 1'b1;
    @(posedge clk); #1; start_v[g] = 1'b0; start_edge = cyc_cnt;
  endtask

  task automatic wait_done(input int g, input int d0, input int budget, input string tag);
    int n;
    n = 0;
    while (done_n_of(g) == d0 && n < budget) begin @(posedge clk); n++; end
    chk({tag, "_done_seen"}, done_n_of(g) != d0, 1);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
  endtask

  initial begin
    int base, d0, v0;
    for (int g = 0; g < 3; g++) begin start_v[g] = 1'b0; pc_v[g] = 32'h0; cyc_v[g] = 32'h0; end
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + k;
    for (int k = 0; k < 16; k++) mem[k] = 32'hA000_0000 + k;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", g_dut[0].busy_s, 0);
    chk("rst_done", g_dut[0].done_s, 0);
    chk("rst_valid", g_dut[0].valid_s, 0);
    chk("rst_txd", g_dut[0].txd_s, 0);
    chk("rst_reg_sel", g_dut[0].reg_sel_s, 0);
    chk("rst_mem_addr", g_dut[0].mem_addr_s, 0);
    reset = 1'b0;

    // Basic dump with the reference contents.
    pc_v[0] = 32'h0000_0010; cyc_v[0] = 32'h0000_002A;
    base = cap_n_of(0); d0 = done_n_of(0);
    start_pulse(0);
    chk("basic_busy", g_dut[0].busy_s, 1);
    chk("basic_valid_in_addr", g_dut[0].valid_s, 0);
    wait_done(0, d0, 400, "basic");
    chk("basic_latency", done_at_of(0) - start_edge, 300);
    chk("basic_mem_addr_end", g_dut[0].mem_addr_s, 32'h3C);
    repeat (5) @(posedge clk);
    #1;
    chk("basic_busy_after", g_dut[0].busy_s, 0);
    chk("basic_one_done", done_n_of(0) - d0, 1);
    build_exp(32, 16, 32'h10, 32'h2A);
    check_frame(0, base, "basic");
    chk("basic_byte3", cap_of(0, base + 3), 8'h10);
    chk("basic_byte7", cap_of(0, base + 7), 8'h2A);
    chk("basic_byte8", cap_of(0, base + 8), 8'h10);
    chk("basic_last", cap_of(0, base + 199), 8'h0F);

    // Backpressure: ready high one cycle of every three, random contents.
    fill_random();
    pc_v[0] = $urandom; cyc_v[0] = $urandom;
    build_exp(32, 16, pc_v[0], cyc_v[0]);
    base = cap_n_of(0); d0 = done_n_of(0); v0 = g_dut[0].viol;
    bp = 1'b1;
    start_pulse(0);
    wait_done(0, d0, 1500, "bp");
    repeat (5) @(posedge clk);
    #1;
    bp = 1'b0;
    check_frame(0, base, "bp");
    chk("bp_stall_stable", g_dut[0].viol - v0, 0);
    chk("bp_one_done", done_n_of(0) - d0, 1);

    // Snapshot coherence and start-while-busy.
    pc_v[0] = 32'h0000_0010; cyc_v[0] = 32'h0000_002A;
    build_exp(32, 16, 32'h10, 32'h2A);
    base = cap_n_of(0); d0 = done_n_of(0);
    start_pulse(0);
    @(posedge clk); #1;
    pc_v[0] = 32'hDEAD_BEEF; cyc_v[0] = 32'h1234_5678;
    repeat (40) @(posedge clk);
    #1; start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    wait_done(0, d0, 400, "snap");
    repeat (30) @(posedge clk);
    #1;
    check_frame(0, base, "snap");
    chk("snap_one_done", done_n_of(0) - d0, 1);
    chk("snap_idle", g_dut[0].busy_s, 0);

    // Reset in the middle of register 5.
    fill_random();
    pc_v[0] = $urandom; cyc_v[0] = $urandom;
    base = cap_n_of(0); d0 = done_n_of(0);
    start_pulse(0);
    for (int n = 0; n < 300 && cap_n_of(0) - base < 30; n++) @(posedge clk);
    #1;
    chk("pre_rst_reg_sel", g_dut[0].reg_sel_s, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", g_dut[0].valid_s, 0);
    chk("midrst_busy", g_dut[0].busy_s, 0);
    chk("midrst_done", g_dut[0].done_s, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", done_n_of(0) - d0, 0);
    pc_v[0] = $urandom; cyc_v[0] = $urandom;
    build_exp(32, 16, pc_v[0], cyc_v[0]);
    base = cap_n_of(0); d0 = done_n_of(0);
    start_pulse(0);
    wait_done(0, d0, 400, "fresh");
    chk("fresh_latency", done_at_of(0) - start_edge, 300);
    repeat (3) @(posedge clk);
    #1;
    check_frame(0, base, "fresh");

    // Small configurations, READ_LATENCY 0 and 2.
    for (int g = 1; g < 3; g++) begin
      fill_random();
      pc_v[g] = $urandom; cyc_v[g] = $urandom;
      build_exp(4, 1, pc_v[g], cyc_v[g]);
      base = cap_n_of(g); d0 = done_n_of(g);
      start_pulse(g);
      wait_done(g, d0, 200, (g == 1) ? "rl0" : "rl2");
      chk((g == 1) ? "rl0_latency" : "rl2_latency", done_at_of(g) - start_edge, (g == 1) ? 35 : 49);
      repeat (5) @(posedge clk);
      #1;
      check_frame(g, base, (g == 1) ? "rl0" : "rl2");
      chk((g == 1) ? "rl0_one_done" : "rl2_one_done", done_n_of(g) - d0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
